// File: rtl/reg_file.sv
// Architectural register file with rename-status table.
// Commits retire values; renames mark registers pending on a ROB id.
module reg_file #(
  parameter int REG_NUM      = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ROB_ID_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic                    rollback,
  input  logic                    commit_en,
  input  logic [4:0]              commit_rd,
  input  logic [DATA_WIDTH-1:0]   commit_val,
  input  logic [ROB_ID_WIDTH-1:0] commit_alias,
  input  logic                    rename_en,
  input  logic [4:0]              rename_rd,
  input  logic [ROB_ID_WIDTH-1:0] rename_alias,
  input  logic [4:0]              rs1_idx,
  input  logic [4:0]              rs2_idx,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  output logic [ROB_ID_WIDTH-1:0] rs1_alias,
  output logic [ROB_ID_WIDTH-1:0] rs2_alias,
  output logic [DATA_WIDTH-1:0]   rs1_val,
  output logic [DATA_WIDTH-1:0]   rs2_val
);

  typedef struct packed {
    logic                    busy;
    logic [ROB_ID_WIDTH-1:0] id;
    logic [DATA_WIDTH-1:0]   val;
  } q_t;

  logic [DATA_WIDTH-1:0]   r_val   [REG_NUM];
  logic [ROB_ID_WIDTH-1:0] r_alias [REG_NUM];
  logic [REG_NUM-1:0]      r_busy;

  logic w_commit;
  logic w_rename;
  logic w_match;
  q_t   w_q1;
  q_t   w_q2;

  assign w_commit = rdy && commit_en && (commit_rd != 5'd0);
  assign w_rename = rdy && rename_en && (rename_rd != 5'd0)
                    && !rollback;
  assign w_match  = (r_alias[commit_rd] == commit_alias);

  // Rollback and rename are placed after commit so they win on the same rd.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_val[i]   <= '0;
        r_alias[i] <= '0;
      end
      r_busy <= '0;
    end else if (rdy) begin
      if (w_commit) begin
        r_val[commit_rd] <= commit_val;
        if (w_match) begin
          r_busy[commit_rd]  <= 1'b0;
          r_alias[commit_rd] <= '0;
        end
      end
      if (rollback) begin
        r_busy <= '0;
        for (int i = 0; i < REG_NUM; i++) begin
          r_alias[i] <= '0;
        end
      end else if (w_rename) begin
        r_busy[rename_rd]  <= 1'b1;
        r_alias[rename_rd] <= rename_alias;
      end
    end
  end

  function automatic q_t query(input logic [4:0] idx);
    q_t q;
    q.busy = r_busy[idx];
    q.id   = r_alias[idx];
    q.val  = r_val[idx];
    if (w_commit && (commit_rd == idx)) begin
      q.val = commit_val;
      if (w_match) begin
        q.busy = 1'b0;
        q.id   = '0;
      end
    end
    if (idx == 5'd0) q = '0;
    return q;
  endfunction

  always_comb begin
    w_q1 = query(rs1_idx);
    w_q2 = query(rs2_idx);
  end

  assign rs1_busy  = w_q1.busy;
  assign rs1_alias = w_q1.id;
  assign rs1_val   = w_q1.val;
  assign rs2_busy  = w_q2.busy;
  assign rs2_alias = w_q2.id;
  assign rs2_val   = w_q2.val;

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus
// randomized traffic against an array-based reference model.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        commit_en, rename_en;
  logic [4:0]  commit_rd, rename_rd, rs1_idx, rs2_idx;
  logic [31:0] commit_val;
  logic [3:0]  commit_alias, rename_alias;
  logic        rs1_busy, rs2_busy;
  logic [3:0]  rs1_alias, rs2_alias;
  logic [31:0] rs1_val, rs2_val;

  int total = 0;
  int bad   = 0;

  bit [31:0] m_val   [32];
  bit        m_busy  [32];
  bit [3:0]  m_alias [32];

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .commit_en(commit_en), .commit_rd(commit_rd),
    .commit_val(commit_val), .commit_alias(commit_alias),
    .rename_en(rename_en), .rename_rd(rename_rd),
    .rename_alias(rename_alias),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_alias(rs1_alias), .rs2_alias(rs2_alias),
    .rs1_val(rs1_val), .rs2_val(rs2_val)
  );

  task automatic idle();
    rst = 0; rdy = 1; rollback = 0;
    commit_en = 0; commit_rd = 0; commit_val = 0; commit_alias = 0;
    rename_en = 0; rename_rd = 0; rename_alias = 0;
  endtask

  // Expected query answer from architectural state plus this cycle's commit.
  task automatic model_q(input logic [4:0] idx, output bit eb,
                         output bit [3:0] ea, output bit [31:0] ev);
    eb = 0; ea = 0; ev = 0;
    if (idx != 0) begin
      eb = m_busy[idx]; ea = m_alias[idx]; ev = m_val[idx];
      if (rdy && commit_en && commit_rd == idx) begin
        ev = commit_val;
        if (m_alias[idx] == commit_alias) begin eb = 0; ea = 0; end
      end
    end
  endtask

  // Advance one clock, applying the architectural rules to the model.
  task automatic step();
    bit [31:0] nv [32];
    bit        nb [32];
    bit [3:0]  na [32];
    nv = m_val; nb = m_busy; na = m_alias;
    if (rst) begin
      foreach (nv[i]) begin nv[i] = 0; nb[i] = 0; na[i] = 0; end
    end else if (rdy) begin
      if (commit_en && commit_rd != 0) begin
        nv[commit_rd] = commit_val;
        if (m_alias[commit_rd] == commit_alias) begin
          nb[commit_rd] = 0; na[commit_rd] = 0;
        end
      end
      if (rollback) begin
        foreach (nb[i]) begin nb[i] = 0; na[i] = 0; end
      end else if (rename_en && rename_rd != 0) begin
        nb[rename_rd] = 1; na[rename_rd] = rename_alias;
      end
    end
    @(posedge clk); #1;
    m_val = nv; m_busy = nb; m_alias = na;
  endtask

  task automatic test_reset();
    idle(); rst = 1; step(); step(); rst = 0;
    rs1_idx = 5; rs2_idx = 0; #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== 37'd0) begin
      bad++;
      $display("FAIL reset_x5 got %b/%0d/%h want 0/0/0",
               rs1_busy, rs1_alias, rs1_val);
    end
    commit_en = 1; commit_rd = 0; commit_val = 32'hDEAD; #1;
    total++;
    if ({rs2_busy, rs2_alias, rs2_val} !== 37'd0) begin
      bad++;
      $display("FAIL x0_bypass got %b/%0d/%h want 0/0/0",
               rs2_busy, rs2_alias, rs2_val);
    end
    step(); idle(); #1;
    total++;
    if (rs2_val !== 32'd0) begin
      bad++; $display("FAIL x0_write got %h want 0", rs2_val);
    end
  endtask

  task automatic test_rename_commit();
    rename_en = 1; rename_rd = 3; rename_alias = 4;
    step(); idle(); rs1_idx = 3; #1;
    total++;
    if ({rs1_busy, rs1_alias} !== {1'b1, 4'd4}) begin
      bad++;
      $display("FAIL rename_x3 got %b/%0d want 1/4", rs1_busy, rs1_alias);
    end
    commit_en = 1; commit_rd = 3; commit_val = 32'h12; commit_alias = 4;
    #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b0, 4'd0, 32'h12}) begin
      bad++;
      $display("FAIL bypass_x3 got %b/%0d/%h want 0/0/12",
               rs1_busy, rs1_alias, rs1_val);
    end
    step(); idle(); #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b0, 4'd0, 32'h12}) begin
      bad++;
      $display("FAIL persist_x3 got %b/%0d/%h want 0/0/12",
               rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_younger_rename();
    rename_en = 1; rename_rd = 7; rename_alias = 2; step();
    rename_alias = 5; step(); idle();
    commit_en = 1; commit_rd = 7; commit_val = 32'h99; commit_alias = 2;
    rs2_idx = 7; #1;
    total++;
    if ({rs2_busy, rs2_alias, rs2_val} !== {1'b1, 4'd5, 32'h99}) begin
      bad++;
      $display("FAIL stale_bypass_x7 got %b/%0d/%h want 1/5/99",
               rs2_busy, rs2_alias, rs2_val);
    end
    step(); idle(); #1;
    total++;
    if ({rs2_busy, rs2_alias, rs2_val} !== {1'b1, 4'd5, 32'h99}) begin
      bad++;
      $display("FAIL younger_x7 got %b/%0d/%h want 1/5/99",
               rs2_busy, rs2_alias, rs2_val);
    end
  endtask

  task automatic test_same_cycle();
    commit_en = 1; commit_rd = 9; commit_val = 32'h77; commit_alias = 3;
    rename_en = 1; rename_rd = 9; rename_alias = 6;
    step(); idle(); rs1_idx = 9; #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b1, 4'd6, 32'h77}) begin
      bad++;
      $display("FAIL same_cycle_x9 got %b/%0d/%h want 1/6/77",
               rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_rollback();
    rename_en = 1; rename_rd = 1; rename_alias = 1; step();
    rename_rd = 2; rename_alias = 2; step(); idle();
    rollback = 1;
    commit_en = 1; commit_rd = 1; commit_val = 32'h40; commit_alias = 1;
    rename_en = 1; rename_rd = 4; rename_alias = 7;
    step(); idle();
    rs1_idx = 1; rs2_idx = 2; #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b0, 4'd0, 32'h40}) begin
      bad++;
      $display("FAIL rollback_x1 got %b/%0d/%h want 0/0/40",
               rs1_busy, rs1_alias, rs1_val);
    end
    total++;
    if ({rs2_busy, rs2_alias} !== 5'd0) begin
      bad++;
      $display("FAIL rollback_x2 got %b/%0d want 0/0", rs2_busy, rs2_alias);
    end
    rs1_idx = 4; rs2_idx = 7; #1;
    total++;
    if ({rs1_busy, rs1_alias} !== 5'd0) begin
      bad++;
      $display("FAIL rollback_x4 got %b/%0d want 0/0", rs1_busy, rs1_alias);
    end
    total++;
    if ({rs2_busy, rs2_alias, rs2_val} !== {1'b0, 4'd0, 32'h99}) begin
      bad++;
      $display("FAIL rollback_x7 got %b/%0d/%h want 0/0/99",
               rs2_busy, rs2_alias, rs2_val);
    end
  endtask

  task automatic test_rdy_hold();
    rename_en = 1; rename_rd = 5; rename_alias = 3; step(); idle();
    rdy = 0;
    commit_en = 1; commit_rd = 5; commit_val = 32'h55; commit_alias = 3;
    rename_en = 1; rename_rd = 6; rename_alias = 8;
    rs1_idx = 5; rs2_idx = 6; #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b1, 4'd3, 32'h0}) begin
      bad++;
      $display("FAIL rdy0_bypass got %b/%0d/%h want 1/3/0",
               rs1_busy, rs1_alias, rs1_val);
    end
    step(); idle(); #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val, rs2_busy} !==
        {1'b1, 4'd3, 32'h0, 1'b0}) begin
      bad++;
      $display("FAIL rdy0_hold got %b/%0d/%h x6busy=%b want 1/3/0 0",
               rs1_busy, rs1_alias, rs1_val, rs2_busy);
    end
    commit_en = 1; commit_rd = 5; commit_val = 32'h55; commit_alias = 3;
    step(); idle(); #1;
    total++;
    if ({rs1_busy, rs1_alias, rs1_val} !== {1'b0, 4'd0, 32'h55}) begin
      bad++;
      $display("FAIL rdy1_resume got %b/%0d/%h want 0/0/55",
               rs1_busy, rs1_alias, rs1_val);
    end
  endtask

  task automatic test_random();
    bit        eb;
    bit [3:0]  ea;
    bit [31:0] ev;
    for (int n = 0; n < 400; n++) begin
      rst          = ($urandom_range(0, 59) == 0);
      rdy          = ($urandom_range(0, 9) != 0);
      rollback     = ($urandom_range(0, 15) == 0);
      commit_en    = $urandom_range(0, 1);
      commit_rd    = 5'($urandom_range(0, 7));
      commit_val   = $urandom;
      commit_alias = 4'($urandom_range(1, 15));
      rename_en    = $urandom_range(0, 1);
      rename_rd    = 5'($urandom_range(0, 7));
      rename_alias = 4'($urandom_range(1, 15));
      rs1_idx      = 5'($urandom_range(0, 7));
      rs2_idx      = 5'($urandom_range(0, 31));
      // Bias commits toward the pending alias so bypasses and clears occur.
      if ($urandom_range(0, 1) == 1) commit_alias = m_alias[commit_rd];
      #1;
      if (!rst) begin
        model_q(rs1_idx, eb, ea, ev);
        total++;
        if ({rs1_busy, rs1_alias, rs1_val} !== {eb, ea, ev}) begin
          bad++;
          $display("FAIL rand_rs1 n=%0d x%0d got %b/%0d/%h want %b/%0d/%h",
                   n, rs1_idx, rs1_busy, rs1_alias, rs1_val, eb, ea, ev);
        end
        model_q(rs2_idx, eb, ea, ev);
        total++;
        if ({rs2_busy, rs2_alias, rs2_val} !== {eb, ea, ev}) begin
          bad++;
          $display("FAIL rand_rs2 n=%0d x%0d got %b/%0d/%h want %b/%0d/%h",
                   n, rs2_idx, rs2_busy, rs2_alias, rs2_val, eb, ea, ev);
        end
      end
      step();
    end
    idle();
  endtask

  initial begin
    idle(); rs1_idx = 0; rs2_idx = 0;
    foreach (m_val[i]) begin m_val[i] = 0; m_busy[i] = 0; m_alias[i] = 0; end
    @(posedge clk); #1;
    test_reset();
    test_rename_commit();
    test_younger_rename();
    test_same_cycle();
    test_rollback();
    test_rdy_hold();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
